// File: rtl/cs_sched_pkg.sv
// cs_sched_pkg: shared latency defaults and config-select encodings for the channel scheduler
package cs_sched_pkg;
  localparam int DEF_DP_LAT = 18;
  localparam int DEF_MULT_OFS = 2;
  typedef enum logic [1:0] {
    CFG_MEAN = 2'd0,
    CFG_STD  = 2'd1,
    CFG_EN   = 2'd2,
    CFG_RSVD = 2'd3
  } cfg_sel_e;
endpackage

// File: rtl/cs_rr_arbiter.sv
// cs_rr_arbiter: picks the first requester at or after ptr, wrapping modulo NUM_CH
module cs_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int TAG_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [TAG_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [TAG_W-1:0]  idx,
  output logic [TAG_W-1:0]  next_ptr
);
  always_comb begin
    int j;
    logic found;
    j = 0;
    found = 1'b0;
    idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_CH;
      if (req[j]) begin
        found = 1'b1;
        idx = TAG_W'(j);
      end
    end
    grant = found ? {{(NUM_CH-1){1'b0}}, 1'b1} << idx : '0;
    next_ptr = (idx == TAG_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/cs_channel_sched.sv
// cs_channel_sched: round-robin share of one center/scale datapath across NUM_CH ADC channels
// Define CS_SCHED_PERF_EN to add per-channel saturating grant counters on perf_cnt.
module cs_channel_sched
  import cs_sched_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int TAG_W    = $clog2(NUM_CH),
  parameter int DP_LAT   = DEF_DP_LAT,
  parameter int MULT_OFS = DEF_MULT_OFS
) (
  input  logic                 clk,
  input  logic                 GlobalReset,
  input  logic [21*NUM_CH-1:0] ch_x_adc,
  input  logic [NUM_CH-1:0]    ch_srdy,
  output logic [NUM_CH-1:0]    ch_grant,
  input  logic                 cfg_we,
  input  logic [TAG_W-1:0]     cfg_ch,
  input  logic [1:0]           cfg_sel,
  input  logic [31:0]          cfg_data,
  output logic [20:0]          dp_x_adc,
  output logic                 dp_srdyi,
  output logic [31:0]          dp_mean,
  output logic [31:0]          dp_std,
  input  logic [31:0]          dp_x_centScale,
  input  logic                 dp_srdyo,
  output logic [31:0]          out_data,
  output logic [TAG_W-1:0]     out_ch,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 err_tag
`ifdef CS_SCHED_PERF_EN
  ,
  output logic [16*NUM_CH-1:0] perf_cnt
`endif
);
  logic [31:0]       mean_r [NUM_CH];
  logic [31:0]       std_r  [NUM_CH];
  logic [NUM_CH-1:0] en;
  logic [TAG_W-1:0]  rr_ptr, idx, next_ptr;
  logic [DP_LAT-1:0] pv;
  logic [TAG_W-1:0]  pt [DP_LAT];
  cs_rr_arbiter #(.NUM_CH(NUM_CH), .TAG_W(TAG_W)) u_arb (
    .req      (ch_srdy & en & {NUM_CH{GlobalReset}}),
    .ptr      (rr_ptr),
    .grant    (ch_grant),
    .idx      (idx),
    .next_ptr (next_ptr)
  );
  assign dp_srdyi = |ch_grant;
  assign dp_x_adc = dp_srdyi ? ch_x_adc[21*idx +: 21] : '0;
  assign dp_mean  = pv[MULT_OFS-1] ? mean_r[pt[MULT_OFS-1]] : '0;
  assign dp_std   = pv[MULT_OFS-1] ? std_r[pt[MULT_OFS-1]] : '0;
  assign busy     = |pv;
  always_ff @(posedge clk or negedge GlobalReset)
    if (!GlobalReset) begin
      en <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mean_r[i] <= '0;
        std_r[i] <= '0;
      end
    end else if (cfg_we) begin
      if (cfg_sel == CFG_MEAN) mean_r[cfg_ch] <= cfg_data;
      if (cfg_sel == CFG_STD) std_r[cfg_ch] <= cfg_data;
      if (cfg_sel == CFG_EN) en[cfg_ch] <= cfg_data[0];
    end
  // tag pipe tracks the datapath so each result and multiplier stage knows its channel
  always_ff @(posedge clk or negedge GlobalReset)
    if (!GlobalReset) begin
      rr_ptr <= '0;
      pv <= '0;
      for (int i = 0; i < DP_LAT; i++) pt[i] <= '0;
      out_data <= '0;
      out_ch <= '0;
      out_valid <= 1'b0;
      err_tag <= 1'b0;
    end else begin
      if (dp_srdyi) rr_ptr <= next_ptr;
      pv <= {pv[DP_LAT-2:0], dp_srdyi};
      pt[0] <= idx;
      for (int i = 1; i < DP_LAT; i++) pt[i] <= pt[i-1];
      out_valid <= dp_srdyo;
      if (dp_srdyo) begin
        out_data <= dp_x_centScale;
        out_ch <= pt[DP_LAT-1];
      end
      if (dp_srdyo != pv[DP_LAT-1]) err_tag <= 1'b1;
    end
`ifdef CS_SCHED_PERF_EN
  always_ff @(posedge clk or negedge GlobalReset)
    if (!GlobalReset) perf_cnt <= '0;
    else
      for (int i = 0; i < NUM_CH; i++)
        if (ch_grant[i] && perf_cnt[16*i +: 16] != 16'hFFFF) perf_cnt[16*i +: 16] <= perf_cnt[16*i +: 16] + 16'd1;
`endif
endmodule
